// File: rtl/test_chan_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ valid/ready requesters onto one registered channel.
// Optional stall watchdog enabled by defining TEST_CHAN_ARB_TIMEOUT_EN.
module test_chan_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_REQ-1:0]                           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]                    req_data,
  output logic [NUM_REQ-1:0]                           req_ready,
  output logic                                         out_valid,
  output logic [DATA_W-1:0]                            out_data,
  input  logic                                         out_ready,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                                         busy,
  output logic                                         timeout
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       ptr_q, ptr_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_REQ-1:0]  req_ready_c;
  logic                found;
  logic [GW-1:0]       win;

  // First valid requester scanning upward from ptr with wrap.
  always_comb begin
    int j;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_valid[GW'(j)]) begin
        found = 1'b1;
        win   = GW'(j);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    req_ready_c = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready_c[win] = 1'b1;
          state_d          = HOLD;
          out_valid_d      = 1'b1;
          data_d           = req_data[int'(win)*DATA_W +: DATA_W];
          grant_d          = win;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          ptr_d       = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
    end
  end

  // Strobe suppressed while reset is asserted so no requester sees a capture.
  assign req_ready = rst_n ? req_ready_c : '0;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == HOLD);

`ifdef TEST_CHAN_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  // Saturating stall counter; flag is sticky until reset.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (state_q == IDLE) begin
      if (found) cnt_d = '0;
    end else if (out_ready) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(TIMEOUT_CYC)) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_d == CW'(TIMEOUT_CYC)) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^32'(TIMEOUT_CYC);
  assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_test_chan_arbiter.sv
// Randomized bench for test_chan_arbiter against a transaction-level model, plus directed checks.
module tb_test_chan_arbiter;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int GW   = 2;
  localparam int TCYC = 64;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [GW-1:0]  grant_id;
  logic           busy;
  logic           timeout;

  test_chan_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: word held or not, rotation start, captured word/owner, stall count.
  bit          m_hold;
  int          m_ptr;
  int          m_gid;
  logic [W-1:0] m_data;
  int          m_cnt;
  bit          m_tout;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_winner();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_hold = 0; m_ptr = 0; m_gid = 0; m_data = '0; m_cnt = 0; m_tout = 0;
  endtask

  task automatic compare_all();
    int w;
    logic [N-1:0] er;
    w  = m_winner();
    er = '0;
    if (rst_n && !m_hold && w >= 0) er[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("out_valid", 64'(out_valid), 64'(m_hold));
    chk("out_data",  64'(out_data),  64'(m_data));
    chk("grant_id",  64'(grant_id),  64'(m_gid));
    chk("busy",      64'(busy),      64'(m_hold));
`ifdef TEST_CHAN_ARB_TIMEOUT_EN
    chk("timeout",   64'(timeout),   64'(m_tout));
`else
    chk("timeout",   64'(timeout),   64'(0));
`endif
  endtask

  // One cycle: check at negedge+1, then advance model across the rising edge.
  task automatic step();
    int w;
    #1;
    compare_all();
    w = m_winner();
    @(posedge clk);
    if (!m_hold) begin
      if (w >= 0) begin
        m_hold = 1; m_gid = w; m_data = req_data[w*W +: W]; m_cnt = 0;
      end
    end else if (out_ready) begin
      m_hold = 0; m_ptr = (m_gid + 1) % N; m_cnt = 0;
    end else begin
      if (m_cnt < TCYC) m_cnt++;
      if (m_cnt == TCYC) m_tout = 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    out_ready = 1'b0;
    m_reset();
    repeat (10) @(negedge clk);
    #1;
    compare_all();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_grant_id",  64'(grant_id),  64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    rst_n     = 1'b1;
    req_valid = '0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

  initial begin
    int gq[$];
    int exp_seq[5];
    exp_seq = '{0, 1, 2, 3, 0};
    req_data  = '0;
    req_valid = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;

    do_reset();

    // Single requester 2.
    req_data[2*W +: W] = 32'h12345678;
    req_valid = 4'b0100;
    out_ready = 1'b1;
    #1;
    chk("t2_req_ready", 64'(req_ready), 64'(4'b0100));
    step();
    req_valid = '0;
    chk("t2_out_valid", 64'(out_valid), 64'(1));
    chk("t2_out_data",  64'(out_data),  64'(32'h12345678));
    chk("t2_grant_id",  64'(grant_id),  64'(2));
    step();
    chk("t2_out_valid_drop", 64'(out_valid), 64'(0));

    // All valid from ptr=0 rotates 0,1,2,3,0.
    do_reset();
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_data = {$urandom, $urandom, $urandom, $urandom};
      step();
      if (out_valid) gq.push_back(int'(grant_id));
    end
    chk("t3_count", 64'(gq.size()), 64'(5));
    for (int i = 0; i < 5 && i < gq.size(); i++) chk("t3_seq", 64'(gq[i]), 64'(exp_seq[i]));

    // Backpressure on requester 1 (ptr is now 1).
    req_valid = 4'b0010;
    req_data[1*W +: W] = 32'hA5A5A5A5;
    out_ready = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      req_valid = 4'($urandom);
      req_data  = {$urandom, $urandom, $urandom, $urandom};
      step();
      chk("t4_hold_data", 64'(out_data), 64'(32'hA5A5A5A5));
      chk("t4_busy",      64'(busy),     64'(1));
    end
    req_valid = '0;
    out_ready = 1'b1;
    step();
    chk("t4_release", 64'(out_valid), 64'(0));

    // Move ptr to 3, then wrap/skip with 4'b0011.
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step();
    req_valid = 4'b0011;
    step();
    chk("t5_first",  64'(grant_id), 64'(0));
    step();
    step();
    chk("t5_second", 64'(grant_id), 64'(1));
    step();

    // Reset while holding a word drops out_valid immediately.
    req_valid = 4'b1000;
    out_ready = 1'b0;
    step();
    chk("t7_pre_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("t7_async_valid", 64'(out_valid), 64'(0));
    chk("t7_async_ready", 64'(req_ready), 64'(0));
    do_reset();

`ifdef TEST_CHAN_ARB_TIMEOUT_EN
    req_valid = 4'b0001;
    out_ready = 1'b0;
    step();
    req_valid = '0;
    for (int i = 0; i < TCYC - 1; i++) step();
    chk("t6_before", 64'(timeout), 64'(0));
    step();
    chk("t6_rise", 64'(timeout), 64'(1));
    out_ready = 1'b1;
    step();
    step();
    chk("t6_sticky", 64'(timeout), 64'(1));
    do_reset();
    chk("t6_cleared", 64'(timeout), 64'(0));
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      req_valid = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req_valid = '0;
      req_data  = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 99) < 60);
      if (i > 2000 && i < 2200) out_ready = 1'b0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
